lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
// - CPU-side load/store initiator for the word-addressed data memory.
// - Accepts byte/half/word load/store requests and issues word-aligned req/ack bus transactions.
// - Performs sub-word stores as read-modify-write; sign- or zero-extends loads; flags misaligned or out-of-range accesses.
// - Sits between the MEM stage of the processor and the data memory.
// PARAMETERS
// - MEM_WORDS  3072  memory depth in 32-bit words; byte addr >= 4*MEM_WORDS -> error
// PORTS
// - clk           in   1   clock, rising edge
// - reset         in   1   asynchronous, active-low (0 = reset)
// - cpu_req       in   1   request; sampled only while cpu_ready=1
// - cpu_we        in   1   1=store, 0=load
// - cpu_size      in   2   00=byte, 01=half, 10=word, 11=illegal (error)
// - cpu_sext      in   1   loads: 1=sign-extend, 0=zero-extend
// - cpu_addr      in   32  byte address
// - cpu_wdata     in   32  store data, right-justified
// - cpu_pc        in   32  PC of the access, for trace only
// - cpu_ready     out  1   1 in IDLE only
// - cpu_done      out  1   one-cycle completion pulse
// - cpu_rdata     out  32  load result; valid while cpu_done=1, else 0
// - cpu_err       out  1   error, valid with cpu_done
// - mem_req       out  1   bus request
// - mem_we        out  1   bus write enable
// - mem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
// - mem_wdata     out  32  full word to write
// - mem_ack       in   1   bus acknowledge; mem_rdata valid in ack cycle
// - mem_rdata     in   32  read word
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE; all outputs 0 except cpu_ready=1; latched request regs cleared.
// - Accept: cpu_req & cpu_ready at edge N -> latch we/size/sext/addr/wdata/pc.
// - Error check at accept: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr>=4*MEM_WORDS.
// - Error -> RESP at N+1 with cpu_err=1, cpu_rdata=0; no bus cycle issued.
// - FSM states: IDLE, RD, WR, RESP.
//   - IDLE -> RD   for a load or a sub-word store.
//   - IDLE -> WR   for a word store.
//   - IDLE -> RESP on error.
//   - RD: mem_req=1, mem_we=0; hold until mem_ack. On ack, load -> RESP; sub-word store -> merge into mem_rdata, then WR.
//   - WR: mem_req=1, mem_we=1, mem_wdata stable; hold until mem_ack, then RESP.
//   - RESP: cpu_done=1 for exactly one cycle, then IDLE.
// - Bus rules: mem_addr/mem_we/mem_wdata constant while mem_req=1; mem_req deasserts the cycle after the ack; never two accesses back-to-back without the RESP cycle.
// - Latency, zero-wait memory (ack in the first req cycle):
//   - load / word store: done at N+2;
//   - sub-word store: done at N+3;
//   - each wait cycle adds 1.
// - Byte lane: lane=addr[1:0]. Byte load takes rdata[8*lane+7:8*lane]; half load takes rdata[16*addr[1]+15:16*addr[1]]; extended per the latched sext.
// - Merge: replace only the addressed byte/half with wdata[7:0]/wdata[15:0]; other bytes come from the read word.
// - cpu_req while not ready: ignored; the CPU must hold it until accepted.
// - Reset mid-operation: abort immediately; mem_req drops asynchronously; no done pulse.
// CONFIGURATION
// - LSU_TRACE_EN defined:
//   - on each WR ack, $display("@%h: *%h <= %h", pc, word_addr, merged_word);
//   - word_addr is the word-aligned byte address.
// - LSU_TRACE_EN undefined: no display; logic otherwise identical.
// TESTING
// - Word load, addr 0x10, mem word 0x8899AABB, ack immediate -> done at N+2, rdata=0x8899AABB, err=0.
// - lb sext, addr 0x13, word 0x80112233 -> rdata=0xFFFFFF80. Same with lbu -> 0x00000080.
// - sb 0x5A to addr 0x21, old word 0x11223344:
//   - exactly one read then one write at 0x20, mem_wdata=0x11225A44;
//   - done at N+3.
// - lh at 0x03 -> err=1, done at N+2, no mem_req. sw at 0x3000 with MEM_WORDS=3072 -> err=1.
// - sw 0xDEADBEEF to 0x8 with 2 wait cycles -> mem_req held 3 cycles, signals stable, done at N+4.
// - reset=0 during RD wait -> mem_req=0, cpu_ready=1 immediately. Release reset -> next request proceeds normally.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_master_if
// Purpose : groups the CPU-side request/response handshake and the
//           word-addressed memory bus of the load/store unit.
// Signals : cpu_req/cpu_we/cpu_size/cpu_sext/cpu_addr/cpu_wdata/cpu_pc (CPU -> LSU)
//           cpu_ready/cpu_done/cpu_rdata/cpu_err                    (LSU -> CPU)
//           mem_req/mem_we/mem_addr/mem_wdata                       (LSU -> memory)
//           mem_ack/mem_rdata                                       (memory -> LSU)
// Modports: master = the LSU view, slave = the CPU/memory environment view.
// ---------------------------------------------------------------------------
interface lsu_mem_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_pc;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata, cpu_pc,
    output cpu_ready, cpu_done, cpu_rdata, cpu_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata, cpu_pc,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
// Purpose : CPU-side load/store initiator for a word-addressed data memory.
//           Byte/half/word loads are sign- or zero-extended, sub-word stores
//           are done as read-modify-write, and misaligned, illegal-size or
//           out-of-range accesses complete with cpu_err and no bus cycle.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-low
//           bus   - lsu_mem_master_if.master (CPU handshake + memory bus)
// Params  : MEM_WORDS - memory depth in 32-bit words
// Config  : LSU_TRACE_EN - when defined, every completed write prints
//           "@<pc>: *<word_addr> <= <word>"; logic is otherwise identical.
// ---------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int MEM_WORDS = 3072
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_master_if.master   bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      r_state;
  logic        r_ready, r_done, r_err, r_err_pend;
  logic [31:0] r_rdata;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        r_we, r_sext;
  logic [1:0]  r_size, r_lane;
  logic [15:0] r_wdata_lo;
  logic [31:0] r_pc;
  logic        w_err;
  logic        w_word_store;

  // Select the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return sext ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sext ? {{16{h[15]}}, h} : {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed byte/half; the rest comes from the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] w;
    w = old_word;
    case (size)
      2'b00:   w[{lane, 3'b000} +: 8]    = wdata[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  assign w_err = (bus.cpu_size == 2'b11) ||
                 (bus.cpu_size == 2'b01 && bus.cpu_addr[0]) ||
                 (bus.cpu_size == 2'b10 && bus.cpu_addr[1:0] != 2'b00) ||
                 (bus.cpu_addr >= ADDR_LIMIT);
  assign w_word_store = bus.cpu_we && (bus.cpu_size == 2'b10);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_pend  <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_we        <= 1'b0;
      r_sext      <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      r_wdata_lo  <= '0;
      r_pc        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // cpu_ready is 1 throughout IDLE, so cpu_req alone means accept.
          if (bus.cpu_req) begin
            r_ready    <= 1'b0;
            r_we       <= bus.cpu_we;
            r_size     <= bus.cpu_size;
            r_sext     <= bus.cpu_sext;
            r_lane     <= bus.cpu_addr[1:0];
            r_wdata_lo <= bus.cpu_wdata[15:0];
            r_pc       <= bus.cpu_pc;
            r_mem_addr <= {bus.cpu_addr[31:2], 2'b00};
            if (w_err) begin
              // Spend one cycle in RESP before the done pulse so an error
              // completes with the same latency as a zero-wait load.
              r_state    <= S_RESP;
              r_err_pend <= 1'b1;
            end else if (w_word_store) begin
              r_state     <= S_WR;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= bus.cpu_wdata;
            end else begin
              r_state   <= S_RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (bus.mem_ack) begin
            if (r_we) begin
              // Sub-word store: the write access follows the read directly.
              r_state     <= S_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= store_merge(bus.mem_rdata, r_wdata_lo, r_lane, r_size);
            end else begin
              r_state   <= S_RESP;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
              r_rdata   <= load_extract(bus.mem_rdata, r_lane, r_size, r_sext);
            end
          end
        end
        S_WR: begin
          if (bus.mem_ack) begin
            r_state   <= S_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
`ifdef LSU_TRACE_EN
            $display("@%h: *%h <= %h", r_pc, r_mem_addr, r_mem_wdata);
`endif
          end
        end
        S_RESP: begin
          if (r_err_pend) begin
            r_err_pend <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef LSU_TRACE_EN
  // The PC is only consumed by the write trace.
  logic w_unused_pc;
  assign w_unused_pc = ^r_pc;
`endif

  assign bus.cpu_ready = r_ready;
  assign bus.cpu_done  = r_done;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_err   = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master #(.MEM_WORDS(3072)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  cpu_exp_t cpu_q[$];
  bus_exp_t bus_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int waits  = 0;
  int wcnt   = 0;

  logic [31:0] mem [0:63];
  logic        was_ack;
  logic        stab_bad;
  logic        ref_we;
  logic [31:0] ref_addr, ref_wdata;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Memory slave: acks after 'waits' extra cycles and checks each access
  // against the expected bus queue at the moment it acks.
  always @(negedge clk) begin
    was_ack = bus.mem_ack;
    if (was_ack) wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    if (bus.mem_req) begin
      if (wcnt == 0) begin
        ref_we    = bus.mem_we;
        ref_addr  = bus.mem_addr;
        ref_wdata = bus.mem_wdata;
        stab_bad  = 1'b0;
      end else if (bus.mem_we !== ref_we || bus.mem_addr !== ref_addr ||
                   (ref_we && bus.mem_wdata !== ref_wdata)) begin
        stab_bad = 1'b1;
      end
      if (wcnt == waits) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[7:2]];
        chk("bus_stable", {31'h0, stab_bad}, 32'h0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_access actual=%h required=none", bus.mem_addr);
        end else begin : pop_bus
          bus_exp_t e;
          e = bus_q.pop_front();
          chk("bus_we", {31'h0, bus.mem_we}, {31'h0, e.we});
          chk("bus_addr", bus.mem_addr, e.addr);
          if (e.we) chk("bus_wdata", bus.mem_wdata, e.wdata);
        end
        if (bus.mem_we) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // CPU-side monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (bus.cpu_done) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin : pop_cpu
        cpu_exp_t e;
        e = cpu_q.pop_front();
        chk("cpu_rdata", bus.cpu_rdata, e.rdata);
        chk("cpu_err", {31'h0, bus.cpu_err}, {31'h0, e.err});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_exp_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  // Called at a negedge. lat = edges from accept to the edge that samples done.
  task automatic do_req(input string nm, input logic we, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int t;
    cpu_exp_t e;
    t = 0;
    while (!bus.cpu_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout actual=0 required=1", nm);
    end else begin
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_size  = size;
      bus.cpu_sext  = sext;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cpu_pc    = 32'h1000 + addr;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      cpu_q.push_back(e);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      t = 0;
      while (cpu_q.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (cpu_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL %s done_timeout actual=0 required=1", nm);
        cpu_q.delete();
      end
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_size = 2'b00;
    bus.cpu_sext = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_pc = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("rst_done", {31'h0, bus.cpu_done}, 32'h0);
    chk("rst_err", {31'h0, bus.cpu_err}, 32'h0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Loads
    mem[4] = 32'h8899AABB;
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);
    mem[4] = 32'h80112233;
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lb", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lbu", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lh_hi", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8011, 1'b0, 2);
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lhu_lo", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00002233, 1'b0, 2);
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lb_lane1", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000022, 1'b0, 2);

    // Sub-word stores (read-modify-write)
    mem[8] = 32'h11223344;
    exp_bus(1'b0, 32'h20, 32'h0);
    exp_bus(1'b1, 32'h20, 32'h11225A44);
    do_req("sb", 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000005A, 32'h0, 1'b0, 3);
    chk("mem_after_sb", mem[8], 32'h11225A44);
    exp_bus(1'b0, 32'h20, 32'h0);
    exp_bus(1'b1, 32'h20, 32'hBEEF5A44);
    do_req("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3);
    exp_bus(1'b0, 32'h20, 32'h0);
    exp_bus(1'b1, 32'h20, 32'h77EF5A44);
    do_req("sb_lane3", 1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF77, 32'h0, 1'b0, 3);

    // Errors: no bus access expected
    do_req("lh_misal", 1'b0, 2'b01, 1'b1, 32'h03, 32'h0, 32'h0, 1'b1, 2);
    do_req("sw_oob", 1'b1, 2'b10, 1'b0, 32'h3000, 32'h1, 32'h0, 1'b1, 2);
    do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    do_req("sw_misal", 1'b1, 2'b10, 1'b0, 32'h06, 32'h1, 32'h0, 1'b1, 2);

    // Last valid word is in range
    mem[63] = 32'hCAFEF00D;
    exp_bus(1'b0, 32'h2FFC, 32'h0);
    do_req("lw_last", 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    // Wait states
    waits = 2;
    exp_bus(1'b1, 32'h8, 32'hDEADBEEF);
    do_req("sw_wait2", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 4);
    chk("mem_after_sw", mem[2], 32'hDEADBEEF);
    waits = 1;
    exp_bus(1'b0, 32'h8, 32'h0);
    do_req("lw_wait1", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Reset during a read wait
    waits = 5;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_size = 2'b10;
    bus.cpu_addr = 32'h10;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_wait_req", {31'h0, bus.mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("abort_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("abort_done", {31'h0, bus.cpu_done}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    waits = 0;
    @(negedge clk);
    exp_bus(1'b0, 32'h10, 32'h0);
    do_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80112233, 1'b0, 2);

    repeat (4) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 32'h0);
    chk("cpu_q_drained", cpu_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
